nand_logic_unit: RTL and testbench
==================================

NAND_LOGIC_UNIT -- requirements
Module: nand_logic_unit

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; legal range 1..64.
REQ-002 Parameter CNT_W, default 16, width of the transfer counter; legal range 2..32.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  operand beat present.
REQ-006 Port in_ready  output  1  unit accepts operand beat this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port op  input  3  operation select, sampled with the beat.
REQ-010 Port out_valid  output  1  result beat present.
REQ-011 Port out_ready  input  1  downstream accepts result beat.
REQ-012 Port y  output  WIDTH  registered result.
REQ-013 Port y_zero  output  1  registered flag, y is all zeros.
REQ-014 Port y_ones  output  1  registered flag, y is all ones.
REQ-015 Port xfer_cnt  output  CNT_W  count of accepted result beats.

Function
REQ-016 The op encoding SHALL be: 000 NAND, 001 AND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A (b ignored), 111 pass A.
REQ-017 The operation SHALL be bitwise over all WIDTH bits; no carries, no cross-bit terms.
REQ-018 Input transfer SHALL occur when in_valid and in_ready are both high on a rising edge; output transfer when out_valid and out_ready are both high.
REQ-019 The unit SHALL hold a 2-entry result buffer (main register plus skid register), so in_ready depends only on registered state, never combinationally on out_ready.
REQ-020 in_ready SHALL be high whenever the skid register is empty.
REQ-021 Latency SHALL be 1 cycle: a beat accepted at edge N with an empty buffer appears on y/out_valid after edge N.
REQ-022 With out_ready held high and in_valid held high, the unit SHALL sustain one result per cycle with no bubbles.
REQ-023 When out_valid is high and out_ready is low, y, y_zero, y_ones and out_valid SHALL hold stable until transfer.
REQ-024 Buffer states SHALL be EMPTY, ONE (main valid), TWO (main and skid valid); EMPTY->ONE on input only; ONE->TWO on input without output; TWO->ONE on output (skid moves to main, same edge); ONE->EMPTY on output without input; ONE->ONE on simultaneous input and output.
REQ-025 In state TWO, in_ready SHALL be low and no beat SHALL be accepted.
REQ-026 Results SHALL leave in acceptance order; no beat dropped or duplicated.
REQ-027 y_zero and y_ones SHALL be computed from the same result as y and travel with it; for WIDTH=1 exactly one of them is high.
REQ-028 xfer_cnt SHALL increment by 1 on each output transfer and saturate at all-ones (no wrap).
REQ-029 op, a, b SHALL be ignored in cycles without an input transfer.

Reset
REQ-030 While rst_n is low: state EMPTY, out_valid 0, in_ready 0, y 0, y_zero 1, y_ones 0, xfer_cnt 0, skid register cleared.
REQ-031 Reset assertion SHALL take effect immediately, independent of clk, including mid-transfer; buffered beats are discarded.
REQ-032 in_ready SHALL go high on the first rising edge after rst_n deasserts; no beat accepted before that edge.

Verification
REQ-033 WIDTH=4, op=000, out_ready=1, beats (a,b) = (0000,1111),(0010,0110),(0111,0100),(0000,1110) back-to-back -> y = 1111,1101,1011,1111 on consecutive cycles, y_ones=1 on the 1st and 4th only, xfer_cnt=4.
REQ-034 WIDTH=4, a=1100, b=1010, each op 000..111 -> y = 0111,1000,1110,0001,0110,1001,0011,1100; y_zero=1 only for op=011 with a=b=1111.
REQ-035 out_ready=0, three beats offered -> two accepted, in_ready low after the 2nd, y stable; raise out_ready -> results emerge in order, then the 3rd is accepted.
REQ-036 Random in_valid/out_ready (WIDTH=8, 10000 beats) vs. scoreboard -> no loss, reorder or duplicate; xfer_cnt equals scoreboard count.
REQ-037 CNT_W=2, 5 output transfers -> xfer_cnt 1,2,3,3,3.
REQ-038 rst_n pulsed low between edges in state TWO -> outputs immediately take REQ-030 values; after release, first beat has 1-cycle latency.

Source files
------------

// File: rtl/nand_logic_unit.sv
// Bitwise NAND-family logic unit with a valid/ready handshake and a two-entry skid buffer.
// Tracks how many result beats have been accepted downstream, saturating at all-ones.
module nand_logic_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_ones,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   main_q;
    logic [WIDTH-1:0]   main_d;
    logic [WIDTH-1:0]   skid_q;
    logic [WIDTH-1:0]   skid_d;
    logic [WIDTH-1:0]   res_c;
    logic               ready_q;
    logic               valid_q;
    logic               zero_q;
    logic               ones_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_xfer_c;
    logic               out_xfer_c;

    assign in_xfer_c  = in_valid & ready_q;
    assign out_xfer_c = valid_q & out_ready;

    // Bitwise operation select.
    always_comb begin
        res_c = a;
        case (op)
            3'b000:  res_c = ~(a & b);
            3'b001:  res_c = a & b;
            3'b010:  res_c = a | b;
            3'b011:  res_c = ~(a | b);
            3'b100:  res_c = a ^ b;
            3'b101:  res_c = ~(a ^ b);
            3'b110:  res_c = ~a;
            3'b111:  res_c = a;
            default: res_c = a;
        endcase
    end

    // Buffer occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and the values loaded into main/skid.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer_c) begin
                    main_d  = res_c;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer_c && out_xfer_c) begin
                    main_d = res_c;
                end else if (in_xfer_c) begin
                    skid_d  = res_c;
                    state_d = TWO;
                end else if (out_xfer_c) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // Skid is promoted on the same edge the main entry leaves.
                if (out_xfer_c) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Result, flags and handshake registers; flags travel with the main entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            skid_q  <= '0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            zero_q  <= (main_d == '0);
            ones_q  <= (main_d == '1);
            valid_q <= (state_d != EMPTY);
            ready_q <= (state_d != TWO);
        end
    end

    // Saturating count of accepted output beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_xfer_c && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign y         = main_q;
    assign y_zero    = zero_q;
    assign y_ones    = ones_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_nand_logic_unit.sv
// Bench for nand_logic_unit: an 8-bit and a 4-bit/2-bit-counter instance share one handshake,
// checked every cycle against a queue model plus directed literal expectations.
module tb_nand_logic_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;

    logic        in_ready8, out_valid8, yz8, yo8;
    logic [7:0]  y8;
    logic [15:0] cnt8;
    logic        in_ready4, out_valid4, yz4, yo4;
    logic [3:0]  y4;
    logic [1:0]  cnt2;

    int errors = 0;
    int checks = 0;

    nand_logic_unit #(.WIDTH(8), .CNT_W(16)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a), .b(b), .op(op), .out_valid(out_valid8), .out_ready(out_ready),
        .y(y8), .y_zero(yz8), .y_ones(yo8), .xfer_cnt(cnt8)
    );

    nand_logic_unit #(.WIDTH(4), .CNT_W(2)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a[3:0]), .b(b[3:0]), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
        .y(y4), .y_zero(yz4), .y_ones(yo4), .xfer_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules from the op table; bitwise, so the 4-bit result is the low nibble.
    function automatic logic [7:0] model_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0:    return ~(x & z);
            3'd1:    return x & z;
            3'd2:    return x | z;
            3'd3:    return ~(x | z);
            3'd4:    return x ^ z;
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Model: FIFO of pending results (capacity 2), readiness enabled one edge after reset.
    logic [7:0] q[$];
    bit         ready_en = 1'b0;
    int         m_cnt = 0;
    int         n_push = 0;
    bit         ix, ox;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            ready_en = 1'b0;
            m_cnt    = 0;
        end else begin
            ix = in_valid && ready_en && (q.size() < 2);
            ox = (q.size() > 0) && out_ready;
            if (ox) begin
                void'(q.pop_front());
                m_cnt++;
            end
            if (ix) begin
                q.push_back(model_op(op, a, b));
                n_push++;
            end
            ready_en = 1'b1;
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", 64'(in_ready8 | in_ready4), 64'(0));
            chk("rst_valid", 64'(out_valid8 | out_valid4), 64'(0));
            chk("rst_y", 64'({y8, y4}), 64'(0));
            chk("rst_flags", 64'({yz8, yo8, yz4, yo4}), 64'(4'b1010));
            chk("rst_cnt", 64'({cnt8, cnt2}), 64'(0));
        end else begin
            chk("ready8", 64'(in_ready8), 64'(ready_en && q.size() < 2));
            chk("ready4", 64'(in_ready4), 64'(ready_en && q.size() < 2));
            chk("valid8", 64'(out_valid8), 64'(q.size() > 0));
            chk("valid4", 64'(out_valid4), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("y8", 64'(y8), 64'(q[0]));
                chk("y4", 64'(y4), 64'(q[0][3:0]));
                chk("flags8", 64'({yz8, yo8}), 64'({q[0] == 8'h00, q[0] == 8'hFF}));
                chk("flags4", 64'({yz4, yo4}), 64'({q[0][3:0] == 4'h0, q[0][3:0] == 4'hF}));
            end
            chk("cnt8", 64'(cnt8), 64'(m_cnt));
            chk("cnt2", 64'(cnt2), 64'((m_cnt > 3) ? 3 : m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse between edges; outputs must clear at once, ready returns on the next edge.
    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("pulse_valid", 64'({out_valid8, out_valid4}), 64'(0));
        chk("pulse_ready", 64'({in_ready8, in_ready4}), 64'(0));
        chk("pulse_y", 64'({y8, y4}), 64'(0));
        chk("pulse_flags", 64'({yz8, yo8, yz4, yo4}), 64'(4'b1010));
        chk("pulse_cnt", 64'({cnt8, cnt2}), 64'(0));
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(in_ready4), 64'(1));
        chk("post_rst_valid", 64'(out_valid4), 64'(0));
    endtask

    logic [3:0] exp034 [8];
    logic [3:0] a033 [4];
    logic [3:0] b033 [4];
    logic [3:0] y033 [4];
    logic [1:0] c037 [5];
    int         push_base;
    int         cyc;

    initial begin
        exp034 = '{4'h7, 4'h8, 4'hE, 4'h1, 4'h6, 4'h9, 4'h3, 4'hC};
        a033   = '{4'h0, 4'h2, 4'h7, 4'h0};
        b033   = '{4'hF, 4'h6, 4'h4, 4'hE};
        y033   = '{4'hF, 4'hD, 4'hB, 4'hF};
        c037   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        #23 rst_n = 1'b1;
        tick();
        chk("first_ready", 64'(in_ready4), 64'(1));

        // Every op on a=1100, b=1010, then NOR of all-ones gives zero.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 8'hCC; b = 8'hAA; op = 3'(i); in_valid = 1'b1;
            tick();
            chk("op_table", 64'(y4), 64'(exp034[i]));
        end
        a = 8'hFF; b = 8'hFF; op = 3'b011;
        tick();
        chk("nor_zero", 64'({yz4, yo4}), 64'(2'b10));
        in_valid = 1'b0;
        tick();

        // Back-to-back NAND stream.
        pulse_reset();
        op = 3'b000; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 8'(a033[i]); b = 8'(b033[i]);
            tick();
            chk("nand_y", 64'(y4), 64'(y033[i]));
            chk("nand_ones", 64'(yo4), 64'(i == 0 || i == 3));
        end
        in_valid = 1'b0;
        tick();
        chk("nand_cnt", 64'(cnt8), 64'(4));

        // Narrow counter saturates.
        pulse_reset();
        in_valid = 1'b1; op = 3'b111; a = 8'h01;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_cnt", 64'(cnt2), 64'(c037[i]));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: two accepted, third held off until drain.
        pulse_reset();
        out_ready = 1'b0; op = 3'b111; in_valid = 1'b1; a = 8'h01;
        tick();
        chk("bp_ready1", 64'(in_ready4), 64'(1));
        a = 8'h02;
        tick();
        chk("bp_ready2", 64'(in_ready4), 64'(0));
        a = 8'h03;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_y", 64'(y4), 64'(1));
            chk("bp_hold_rdy", 64'({in_ready4, out_valid4}), 64'(2'b01));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_out2", 64'({in_ready4, y4}), 64'(5'h12));
        tick();
        chk("bp_out3", 64'(y4), 64'(3));
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(out_valid4), 64'(0));

        // Reset while both entries are full.
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h05;
        tick();
        a = 8'h06;
        tick();
        a = 8'h09;
        pulse_reset();
        tick();
        chk("rst_lat_y", 64'({out_valid4, y4}), 64'(5'h19));
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Random traffic, 10000 accepted beats.
        push_base = n_push;
        cyc = 0;
        while ((n_push - push_base) < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 65);
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 3'($urandom);
            tick();
            cyc++;
        end
        chk("rand_beats", 64'((n_push - push_base) >= 10000), 64'(1));
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("rand_drain", 64'(q.size()), 64'(0));
        tick();
        chk("rand_valid", 64'(out_valid8), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
